// File: rtl/reg_file_2r1w_if.sv
// Operand-fetch bus between decode/writeback and the register file.
// Master drives addresses and the writeback port; the register file returns operand data.
interface reg_file_2r1w_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [N-1:0]      rd_data0;
  logic [N-1:0]      rd_data1;
  logic              wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0]      wr_data;

  modport master (
    output rd_addr0, rd_addr1, wr_ena, wr_addr, wr_data,
    input  rd_data0, rd_data1
  );

  modport slave (
    input  rd_addr0, rd_addr1, wr_ena, wr_addr, wr_data,
    output rd_data0, rd_data1
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// 32-entry, 2-read/1-write register file with r0 hardwired to zero and write-to-read bypass.
// Reads are combinational (0 cycles), writes land on the next clk edge; no backpressure.
module reg_file_2r1w #(
  parameter int N      = 32,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  reg_file_2r1w_if.slave  rf
);
  localparam int NREG = 2 ** ADDR_W;

  logic [N-1:0] regs_q [NREG];
  logic [N-1:0] regs_d [NREG];
  logic         wr_act;
  logic         byp0;
  logic         byp1;

  // A write counts only when it will actually commit; the same term gates the bypass,
  // so a write colliding with reset is neither stored nor forwarded.
  always_comb begin
    wr_act = rf.wr_ena && (rf.wr_addr != '0) && !rst;
    regs_d = regs_q;
    regs_d[0] = '0;
    if (wr_act) begin
      regs_d[rf.wr_addr] = rf.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    byp0 = wr_act && (rf.wr_addr == rf.rd_addr0);
    byp1 = wr_act && (rf.wr_addr == rf.rd_addr1);

    rf.rd_data0 = '0;
    if (rf.rd_addr0 != '0) begin
      rf.rd_data0 = byp0 ? rf.wr_data : regs_q[rf.rd_addr0];
    end

    rf.rd_data1 = '0;
    if (rf.rd_addr1 != '0) begin
      rf.rd_data1 = byp1 ? rf.wr_data : regs_q[rf.rd_addr1];
    end
  end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios plus randomized regression
// against an array model of the register file.
module tb_reg_file_2r1w;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] model [32];
  bit   model_known;

  reg_file_2r1w_if #(.N(32), .ADDR_W(5)) rf_if ();

  reg_file_2r1w #(.N(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected read value straight from the architectural rules.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (!rst && rf_if.wr_ena && (rf_if.wr_addr == a)) return rf_if.wr_data;
    return model[a];
  endfunction

  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1);
    rst            = r;
    rf_if.wr_ena   = we;
    rf_if.wr_addr  = wa;
    rf_if.wr_data  = wd;
    rf_if.rd_addr0 = ra0;
    rf_if.rd_addr1 = ra1;
  endtask

  task automatic settle();
    @(negedge clk);
    if (model_known) begin
      check("model_rd0", rf_if.rd_data0, exp_read(rf_if.rd_addr0));
      check("model_rd1", rf_if.rd_data1, exp_read(rf_if.rd_addr1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_known = 1'b1;
    end else if (rf_if.wr_ena && rf_if.wr_addr != 5'd0) begin
      model[rf_if.wr_addr] = rf_if.wr_data;
    end
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    model_known = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Initial reset
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    settle(); tick();

    // Reset clear
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd1);
    settle(); tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    settle();
    check("pre_rst_r5", rf_if.rd_data0, 32'hDEADBEEF);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 16));
      settle();
      check("rst_sweep0", rf_if.rd_data0, 32'h0);
      check("rst_sweep1", rf_if.rd_data1, 32'h0);
      tick();
    end

    // Basic write/read
    drive(1'b0, 1'b1, 5'd7, 32'h0000001F, 5'd0, 5'd0);
    settle(); tick();
    drive(1'b0, 1'b1, 5'd8, 32'h80000000, 5'd0, 5'd0);
    settle(); tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd7);
    settle();
    check("basic_r8", rf_if.rd_data0, 32'h80000000);
    check("basic_r7", rf_if.rd_data1, 32'h0000001F);
    tick();

    // Zero register
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    settle();
    check("zero_same", rf_if.rd_data0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    settle();
    check("zero_next", rf_if.rd_data0, 32'h0);
    tick();

    // Bypass on both ports
    drive(1'b0, 1'b1, 5'd12, 32'hAAAA5555, 5'd0, 5'd0);
    settle(); tick();
    drive(1'b0, 1'b1, 5'd12, 32'h12345678, 5'd12, 5'd12);
    settle();
    check("byp_same0", rf_if.rd_data0, 32'h12345678);
    check("byp_same1", rf_if.rd_data1, 32'h12345678);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd12);
    settle();
    check("byp_next0", rf_if.rd_data0, 32'h12345678);
    check("byp_next1", rf_if.rd_data1, 32'h12345678);
    tick();

    // Back-to-back writes to one address: last wins, newer value bypasses
    drive(1'b0, 1'b1, 5'd9, 32'h0000000A, 5'd9, 5'd0);
    settle(); tick();
    drive(1'b0, 1'b1, 5'd9, 32'h0000000B, 5'd9, 5'd0);
    settle();
    check("b2b_byp", rf_if.rd_data0, 32'h0000000B);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    settle();
    check("b2b_last", rf_if.rd_data0, 32'h0000000B);
    tick();

    // Reset versus write collision
    drive(1'b0, 1'b1, 5'd3, 32'h00000055, 5'd0, 5'd0);
    settle(); tick();
    drive(1'b1, 1'b1, 5'd3, 32'h00000001, 5'd3, 5'd3);
    settle();
    check("coll_old", rf_if.rd_data0, 32'h00000055);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    settle();
    check("coll_after", rf_if.rd_data0, 32'h0);
    tick();

    // Random regression
    for (int c = 0; c < 10000; c++) begin
      logic        r;
      logic        we;
      logic [4:0]  wa;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] wd;
      r   = ($urandom_range(0, 49) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom();
      ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(r, we, wa, wd, ra0, ra1);
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
